fetch_stage: RTL and testbench

Fetch-and-decode stage of the sequential (SEQ) Y86-64 processor. It takes the current PC and a 10-byte instruction window already read from instruction memory starting at PC. It splits out icode, ifun, rA, rB and the constant word, and computes the fall-through PC (valP). It also flags out-of-range PCs and illegal encodings. Downstream are the decode/execute stages and the PC-select logic.

---
 rtl/y86_pkg.sv | 26 ++
 rtl/fetch_len_decode.sv | 61 ++++++
 rtl/fetch_stage.sv | 80 ++++++++
 tb/tb_fetch_stage.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encoding constants: instruction codes, the "no register"
// marker and the byte lengths of each instruction format.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;

    // Instruction lengths in bytes
    localparam logic [3:0] LEN_OP     = 4'd1;   // icode only
    localparam logic [3:0] LEN_REG    = 4'd2;   // icode + register byte
    localparam logic [3:0] LEN_DEST   = 4'd9;   // icode + 8-byte destination
    localparam logic [3:0] LEN_REGVAL = 4'd10;  // icode + registers + 8-byte constant

endpackage

// File: rtl/fetch_len_decode.sv
// Per-icode format decode: whether a register byte and/or constant word
// follow, the total instruction length, and icode/ifun legality.
import y86_pkg::*;

module fetch_len_decode (
    input  logic [3:0] icode,
    input  logic [3:0] ifun,
    output logic       need_regids,
    output logic       need_valc,
    output logic [3:0] len,
    output logic       illegal
);

    // Format table; unknown icodes fall back to a 1-byte illegal instruction
    always_comb begin
        need_regids = 1'b0;
        need_valc   = 1'b0;
        len         = LEN_OP;
        illegal     = 1'b0;
        case (icode)
            IHALT, INOP, IRET: begin
                illegal = (ifun != 4'h0);
            end
            IRRMOVQ: begin
                need_regids = 1'b1;
                len         = LEN_REG;
                illegal     = (ifun > 4'h6);
            end
            IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
                need_regids = 1'b1;
                need_valc   = 1'b1;
                len         = LEN_REGVAL;
                illegal     = (ifun != 4'h0);
            end
            IOPQ: begin
                need_regids = 1'b1;
                len         = LEN_REG;
                illegal     = (ifun > 4'h3);
            end
            IJXX: begin
                need_valc = 1'b1;
                len       = LEN_DEST;
                illegal   = (ifun > 4'h6);
            end
            ICALL: begin
                need_valc = 1'b1;
                len       = LEN_DEST;
                illegal   = (ifun != 4'h0);
            end
            IPUSHQ, IPOPQ: begin
                need_regids = 1'b1;
                len         = LEN_REG;
                illegal     = (ifun != 4'h0);
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fetch_stage.sv
// SEQ Y86-64 fetch stage: slices the 10-byte instruction window into
// fields, computes the fall-through PC and flags memory/encoding errors.
// Purely combinational; rst_n low forces every output to zero.
import y86_pkg::*;

module fetch_stage #(
    parameter int unsigned MEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] PC,
    input  logic [0:79] instruct,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        mem_err,
    output logic        instruct_err
);

    // The stage keeps a clock port only for a uniform stage interface
    logic unused_clk;
    assign unused_clk = clk;

    logic [3:0] icode_raw;
    logic [3:0] ifun_raw;
    logic       need_regids;
    logic       need_valc;
    logic [3:0] len;
    logic       illegal;
    logic       pc_bad;

    assign icode_raw = instruct[0:3];
    assign ifun_raw  = instruct[4:7];
    assign pc_bad    = (PC > 64'(MEM_SIZE - 1));

    fetch_len_decode u_len_decode (
        .icode       (icode_raw),
        .ifun        (ifun_raw),
        .need_regids (need_regids),
        .need_valc   (need_valc),
        .len         (len),
        .illegal     (illegal)
    );

    // Output mux: reset zeroes everything, a bad PC substitutes a nop
    always_comb begin
        icode        = '0;
        ifun         = '0;
        ra           = '0;
        rb           = '0;
        valC         = '0;
        valP         = '0;
        mem_err      = 1'b0;
        instruct_err = 1'b0;
        if (!rst_n) begin
            // all outputs held at zero
        end else if (pc_bad) begin
            icode   = INOP;
            ifun    = 4'h0;
            ra      = RNONE;
            rb      = RNONE;
            valP    = PC;
            mem_err = 1'b1;
        end else begin
            icode        = icode_raw;
            ifun         = ifun_raw;
            ra           = need_regids ? instruct[8:11]  : RNONE;
            rb           = need_regids ? instruct[12:15] : RNONE;
            // Big-endian constant: without a register byte it starts at byte 1
            if (need_valc)
                valC = need_regids ? instruct[16:79] : instruct[8:71];
            valP         = PC + 64'(len);
            instruct_err = illegal;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage with hand-computed expectations.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [63:0] PC;
    logic [0:79] instruct;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        mem_err;
    logic        instruct_err;

    int unsigned n_vec;
    int unsigned n_bad;

    fetch_stage #(.MEM_SIZE(1024)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PC           (PC),
        .instruct     (instruct),
        .icode        (icode),
        .ifun         (ifun),
        .ra           (ra),
        .rb           (rb),
        .valC         (valC),
        .valP         (valP),
        .mem_err      (mem_err),
        .instruct_err (instruct_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive away from the rising edge, let the combinational outputs settle
    task automatic apply(input logic [63:0] pc, input logic [0:79] ins);
        @(negedge clk);
        PC       = pc;
        instruct = ins;
        #2;
    endtask

    task automatic check_all(input string tag,
                             input logic [3:0] e_icode, input logic [3:0] e_ifun,
                             input logic [3:0] e_ra, input logic [3:0] e_rb,
                             input logic [63:0] e_valc, input logic [63:0] e_valp,
                             input logic e_merr, input logic e_ierr);
        check({tag, ".icode"}, 64'(icode), 64'(e_icode));
        check({tag, ".ifun"},  64'(ifun),  64'(e_ifun));
        check({tag, ".ra"},    64'(ra),    64'(e_ra));
        check({tag, ".rb"},    64'(rb),    64'(e_rb));
        check({tag, ".valC"},  valC,       e_valc);
        check({tag, ".valP"},  valP,       e_valp);
        check({tag, ".mem_err"},      64'(mem_err),      64'(e_merr));
        check({tag, ".instruct_err"}, 64'(instruct_err), 64'(e_ierr));
    endtask

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        PC       = 64'd66;
        instruct = 80'h30_53_00_00_00_00_00_00_00_06;
        #2;
        check_all("reset", 4'h0, 4'h0, 4'h0, 4'h0, 64'd0, 64'd0, 1'b0, 1'b0);

        // Release between clock edges: outputs follow inputs without a clock
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        check_all("release", 4'h3, 4'h0, 4'h5, 4'h3, 64'd6, 64'd76, 1'b0, 1'b0);

        apply(64'd66, 80'h35_53_00_00_00_00_00_00_00_06);
        check_all("irmovq_badfun", 4'h3, 4'h5, 4'h5, 4'h3, 64'd6, 64'd76, 1'b0, 1'b1);

        apply(64'd2, 80'h20_03_00_00_00_00_00_00_00_00);
        check_all("rrmovq", 4'h2, 4'h0, 4'h0, 4'h3, 64'd0, 64'd4, 1'b0, 1'b0);

        apply(64'd4, 80'h40_03_00_00_00_00_00_00_00_0F);
        check_all("rmmovq", 4'h4, 4'h0, 4'h0, 4'h3, 64'd15, 64'd14, 1'b0, 1'b0);

        apply(64'd90, 80'h71_00_00_00_00_00_00_00_22_FF);
        check_all("jle", 4'h7, 4'h1, 4'hF, 4'hF, 64'h22, 64'd99, 1'b0, 1'b0);

        apply(64'd171, 80'hA0_0F_12_34_56_78_9A_BC_DE_F0);
        check_all("pushq", 4'hA, 4'h0, 4'h0, 4'hF, 64'd0, 64'd173, 1'b0, 1'b0);

        apply(64'd0, 80'h00_11_22_33_44_55_66_77_88_99);
        check_all("halt", 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 1'b0, 1'b0);

        apply(64'd0, 80'hC0_12_00_00_00_00_00_00_00_00);
        check_all("bad_icode", 4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 1'b0, 1'b1);

        apply(64'd1024, 80'h30_53_00_00_00_00_00_00_00_06);
        check_all("pc_oob", 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1024, 1'b1, 1'b0);

        apply(64'd1023, 80'h10_00_00_00_00_00_00_00_00_00);
        check_all("pc_top", 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1024, 1'b0, 1'b0);

        apply(64'hFFFF_FFFF_FFFF_FFFF, 80'hC7_00_00_00_00_00_00_00_00_00);
        check_all("pc_max", 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);

        apply(64'd8, 80'h80_01_02_03_04_05_06_07_08_09);
        check_all("call", 4'h8, 4'h0, 4'hF, 4'hF, 64'h0102_0304_0506_0708, 64'd17, 1'b0, 1'b0);

        apply(64'd100, 80'h50_7A_11_22_33_44_55_66_77_88);
        check_all("mrmovq", 4'h5, 4'h0, 4'h7, 4'hA, 64'h1122_3344_5566_7788, 64'd110, 1'b0, 1'b0);

        apply(64'd20, 80'h63_12_00_00_00_00_00_00_00_00);
        check_all("opq_xor", 4'h6, 4'h3, 4'h1, 4'h2, 64'd0, 64'd22, 1'b0, 1'b0);

        apply(64'd20, 80'h64_12_00_00_00_00_00_00_00_00);
        check_all("opq_badfun", 4'h6, 4'h4, 4'h1, 4'h2, 64'd0, 64'd22, 1'b0, 1'b1);

        apply(64'd30, 80'h26_45_00_00_00_00_00_00_00_00);
        check_all("cmov_top", 4'h2, 4'h6, 4'h4, 4'h5, 64'd0, 64'd32, 1'b0, 1'b0);

        apply(64'd30, 80'h77_00_00_00_00_00_00_00_10_00);
        check_all("jxx_badfun", 4'h7, 4'h7, 4'hF, 4'hF, 64'h10, 64'd39, 1'b0, 1'b1);

        apply(64'd40, 80'h91_00_00_00_00_00_00_00_00_00);
        check_all("ret_badfun", 4'h9, 4'h1, 4'hF, 4'hF, 64'd0, 64'd41, 1'b0, 1'b1);

        apply(64'd50, 80'hB0_8F_00_00_00_00_00_00_00_00);
        check_all("popq", 4'hB, 4'h0, 4'h8, 4'hF, 64'd0, 64'd52, 1'b0, 1'b0);

        // Asynchronous reset in mid-cycle overrides a live instruction
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_all("reset_mid", 4'h0, 4'h0, 4'h0, 4'h0, 64'd0, 64'd0, 1'b0, 1'b0);
        #1 rst_n = 1'b1;
        #1;
        check_all("release2", 4'hB, 4'h0, 4'h8, 4'hF, 64'd0, 64'd52, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
